// File: rtl/keccak_pkg.sv
// keccak_pkg: shared types, rate table and domain byte for the multi-rate Keccak padder.
// KECCAK_PADDER_SHA3_DOMAIN_EN selects the FIPS-202 domain byte 0x06 instead of Keccak's 0x01.
package keccak_pkg;

    typedef enum logic [1:0] {SHA3_224, SHA3_256, SHA3_384, SHA3_512} mode_e;
    typedef enum logic [1:0] {S_FILL, S_PAD, S_FULL, S_DONE} state_e;

    localparam int RATE_MAX = 1152;

`ifdef KECCAK_PADDER_SHA3_DOMAIN_EN
    localparam logic [7:0] DOMAIN_BYTE = 8'h06;
`else
    localparam logic [7:0] DOMAIN_BYTE = 8'h01;
`endif

    function automatic logic [10:0] rate_bits(mode_e m);
        return m == SHA3_224 ? 11'd1152 : m == SHA3_256 ? 11'd1088 : m == SHA3_384 ? 11'd832 : 11'd576;
    endfunction

    function automatic logic [5:0] words_per_block(mode_e m, int in_w);
        return 6'(in_w == 64 ? rate_bits(m) >> 6 : rate_bits(m) >> 5);
    endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// keccak_pad_word: keeps the valid MSB-aligned bytes of a final word and inserts the domain byte after them.
module keccak_pad_word
    import keccak_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic [IN_W-1:0]             word_i,
    input  logic [$clog2(IN_W/8)-1:0]   byte_num_i,
    input  logic                        is_last_i,
    output logic [IN_W-1:0]             word_o
);

    localparam int BW = $clog2(IN_W/8);

    always_comb begin
        word_o = '0;
        for (int i = 0; i < IN_W/8; i++)
            word_o[IN_W-1-8*i -: 8] = !is_last_i || BW'(i) < byte_num_i ? word_i[IN_W-1-8*i -: 8] :
                                      BW'(i) == byte_num_i ? DOMAIN_BYTE : 8'h00;
    end

endmodule

// File: rtl/keccak_padder_mr.sv
// keccak_padder_mr: packs IN_W-bit words into rate-sized blocks for a run-time SHA-3 mode and appends pad10*1.
// Domain byte chosen by KECCAK_PADDER_SHA3_DOMAIN_EN (see keccak_pkg).
module keccak_padder_mr
    import keccak_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [1:0]                  mode_i,
    input  logic [IN_W-1:0]             in_i,
    input  logic                        in_ready_i,
    input  logic                        is_last_i,
    input  logic [$clog2(IN_W/8)-1:0]   byte_num_i,
    output logic                        buffer_full_o,
    output logic [RATE_MAX-1:0]         out_o,
    output logic                        out_ready_o,
    input  logic                        f_ack_i
);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d, mode_eff;
    logic [5:0]          cnt_q, cnt_d, wpb;
    logic                msg_q, msg_d, last_q, last_d, at_end, wr;
    logic [RATE_MAX-1:0] out_q, out_d;
    logic [IN_W-1:0]     pad_w, wr_w;

    keccak_pad_word #(.IN_W(IN_W)) u_pad (
        .word_i     (in_i),
        .byte_num_i (byte_num_i),
        .is_last_i  (is_last_i),
        .word_o     (pad_w)
    );

    // mode is only sampled on the first word of a message
    assign mode_eff = msg_q ? mode_q : mode_e'(mode_i);
    assign wpb      = words_per_block(mode_eff, IN_W);
    assign at_end   = cnt_q == wpb - 6'd1;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        msg_d   = msg_q;
        last_d  = last_q;
        out_d   = out_q;
        wr      = 1'b0;
        wr_w    = '0;
        case (state_q)
            S_FILL: if (in_ready_i) begin
                wr      = 1'b1;
                wr_w    = pad_w | (is_last_i && at_end ? IN_W'(8'h80) : '0);
                msg_d   = 1'b1;
                mode_d  = mode_eff;
                last_d  = is_last_i;
                state_d = is_last_i && !at_end ? S_PAD : at_end ? S_FULL : S_FILL;
            end
            S_PAD: begin
                wr      = 1'b1;
                wr_w    = at_end ? IN_W'(8'h80) : '0;
                state_d = at_end ? S_FULL : S_PAD;
            end
            S_FULL: if (f_ack_i) begin
                cnt_d   = '0;
                out_d   = '0;
                state_d = last_q ? S_DONE : S_FILL;
            end
            default: ;
        endcase
        if (wr) begin
            cnt_d = cnt_q + 6'd1;
            out_d = out_q | ({wr_w, {(RATE_MAX-IN_W){1'b0}}} >> (IN_W * cnt_q));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FILL;
            mode_q  <= SHA3_224;
            cnt_q   <= '0;
            msg_q   <= 1'b0;
            last_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            msg_q   <= msg_d;
            last_q  <= last_d;
            out_q   <= out_d;
        end
    end

    assign buffer_full_o = state_q != S_FILL;
    assign out_ready_o   = state_q == S_FULL;
    assign out_o         = out_q;

endmodule

// File: tb/tb_keccak_padder_mr.sv
// tb_keccak_padder_mr: randomized bench for keccak_padder_mr (IN_W=32 and IN_W=64) against a byte-level padding model.
module tb_keccak_padder_mr;

    localparam int RM = 1152;
`ifdef KECCAK_PADDER_SHA3_DOMAIN_EN
    localparam logic [7:0] D = 8'h06;
`else
    localparam logic [7:0] D = 8'h01;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
    logic [1:0]    mode = '0;
    logic [63:0]   din = '0;
    logic          in_ready = 1'b0, is_last = 1'b0, f_ack = 1'b0;
    logic [2:0]    bn = '0;
    logic          bf32, bf64, or32, or64, bf, orr;
    logic [RM-1:0] o32, o64, omux;
    logic [63:0]   wq[$];
    int            n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    keccak_padder_mr #(.IN_W(32)) u32 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .in_i(din[31:0]), .in_ready_i(in_ready & ~sel),
        .is_last_i(is_last), .byte_num_i(bn[1:0]), .buffer_full_o(bf32), .out_o(o32),
        .out_ready_o(or32), .f_ack_i(f_ack & ~sel)
    );

    keccak_padder_mr #(.IN_W(64)) u64 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .in_i(din), .in_ready_i(in_ready & sel),
        .is_last_i(is_last), .byte_num_i(bn), .buffer_full_o(bf64), .out_o(o64),
        .out_ready_o(or64), .f_ack_i(f_ack & sel)
    );

    assign bf   = sel ? bf64 : bf32;
    assign orr  = sel ? or64 : or32;
    assign omux = sel ? o64 : o32;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        in_ready = 1'b0;
        is_last  = 1'b0;
        f_ack    = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic fill_random(input int n, input int iw);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(iw == 64 ? {$urandom, $urandom} : {32'h0, $urandom});
    endtask

    // Sends wq as one message, acknowledging each block after a random hold, and checks every block.
    task automatic run(input int m, input int iw, input int bnv);
        int rb = m == 0 ? 144 : m == 1 ? 136 : m == 2 ? 104 : 72;
        int wpb = rb * 8 / iw;
        int n = wq.size();
        logic [7:0] eb[$];
        logic [63:0] e;
        int nblk, idx, blk, cyc, t_last, hold;
        bit acc, la, seen, ackd;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < (i == n - 1 ? bnv : iw / 8); j++) eb.push_back(8'(wq[i] >> (iw - 8 - 8 * j)));
        nblk = eb.size() / rb + 1;
        eb.push_back(D);
        while (eb.size() < nblk * rb) eb.push_back(8'h00);
        eb[nblk*rb-1] = eb[nblk*rb-1] | 8'h80;
        idx = 0; blk = 0; cyc = 0; t_last = -1; seen = 0; ackd = 0;
        hold = $urandom_range(0, 3);
        sel = iw == 64;
        while (blk < nblk && cyc < 3000) begin
            in_ready = idx < n && $urandom_range(0, 3) != 0;
            din      = idx < n ? wq[idx] : 64'h0;
            is_last  = idx == n - 1;
            bn       = 3'(bnv);
            mode     = idx == 0 ? 2'(m) : 2'($urandom);
            f_ack    = 1'b0;
            if (ackd) begin
                check("next_bf", 64'(bf), 64'd0);
                check("next_or", 64'(orr), 64'd0);
                ackd = 0;
            end
            if (orr) begin
                if (!seen) begin
                    seen = 1;
                    if (blk == nblk - 1) check("latency", 64'(cyc - t_last), 64'(wpb - 1 - (n - 1) % wpb));
                    for (int c = 0; c < 18; c++) begin
                        e = '0;
                        for (int j = 0; j < 8; j++) e = {e[55:0], (8 * c + j < rb) ? eb[blk*rb+8*c+j] : 8'h00};
                        check($sformatf("blk%0d_c%0d", blk, c), omux[RM-1-64*c -: 64], e);
                    end
                end
                if (hold > 0) begin
                    hold--;
                    check("hold_bf", 64'(bf), 64'd1);
                end else begin
                    f_ack = 1'b1;
                    blk++;
                    seen = 0;
                    ackd = blk < nblk;
                    hold = $urandom_range(0, 3);
                end
            end else begin
                f_ack = $urandom_range(0, 3) == 0;
            end
            acc = in_ready && !bf;
            @(posedge clk);
            la = acc && idx == n - 1;
            if (acc) idx++;
            @(negedge clk);
            cyc++;
            if (la) t_last = cyc;
        end
        in_ready = 1'b0;
        f_ack    = 1'b0;
        check("blocks", 64'(blk), 64'(nblk));
        check("done_bf", 64'(bf), 64'd1);
        check("done_or", 64'(orr), 64'd0);
    endtask

    initial begin
        int m, iw, n, b;
        do_reset();
        check("rst_or", 64'(or32), 64'd0);
        check("rst_bf", 64'(bf32), 64'd0);
        check("rst_out", 64'(|o32), 64'd0);

        // f_ack while filling must do nothing
        @(negedge clk) f_ack = 1'b1;
        @(negedge clk) f_ack = 1'b0;
        check("fack_fill_bf", 64'(bf32), 64'd0);
        check("fack_fill_or", 64'(or32), 64'd0);

        // "Hello, world!" with 1 valid byte in the last word
        wq = '{64'h48656c6c, 64'h6f2c2077, 64'h6f726c64, 64'h21202020};
        run(1, 32, 1);

        do_reset();
        fill_random(34, 32);
        wq.push_back(64'h0);
        run(1, 32, 0);

        do_reset();
        fill_random(34, 32);
        run(1, 32, 3);

        do_reset();
        fill_random(2, 64);
        run(3, 64, $urandom_range(0, 7));

        for (int t = 0; t < 10; t++) begin
            do_reset();
            iw = $urandom_range(0, 1) ? 64 : 32;
            m  = $urandom_range(0, 3);
            n  = $urandom_range(1, (m == 0 ? 1152 : m == 1 ? 1088 : m == 2 ? 832 : 576) / iw * 2 + 2);
            b  = $urandom_range(0, iw / 8 - 1);
            fill_random(n, iw);
            run(m, iw, b);
        end

        // asynchronous reset while padding
        do_reset();
        sel = 1'b0;
        in_ready = 1'b1; is_last = 1'b1; bn = 3'd2; din = 64'hdeadbeef; mode = 2'd1;
        @(negedge clk);
        in_ready = 1'b0;
        check("pad_bf", 64'(bf32), 64'd1);
        check("pad_or", 64'(or32), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_pad_bf", 64'(bf32), 64'd0);
        check("rst_pad_or", 64'(or32), 64'd0);
        check("rst_pad_out", 64'(|o32), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
